// File: rtl/qspi_req_arbiter_if.sv
// qspi_req_arbiter_if: register-port bus between the arbiter and QSPI_master.
//   write : register write strobe (never set together with a read)
//   be    : byte enables, 4'hF on any access, 4'h0 when idle
//   addr  : register byte address (CCR 0x00, ADR 0x04, DR0 0x08, STA 0x28)
//   wdata : register write data
//   rdata : register read data, combinational from addr
// The master modport is the arbiter side and the slave modport is the QSPI_master side.
interface qspi_req_arbiter_if;
    logic        write;
    logic [3:0]  be;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output write, be, addr, wdata, input rdata);
    modport slave  (input write, be, addr, wdata, output rdata);
endinterface

// File: rtl/qspi_req_arbiter.sv
// qspi_req_arbiter: shares one QSPI_master register port between an instruction
// fetch requester (r0) and a data requester (r1). Each granted request is run as
// DR0 write (writes only), ADR write, CCR write, STA polling, and DR0 readback
// (reads only), and then a one-cycle ack returns to the requester.
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   rN_req_i/we_i/addr_i/ccr_i/wdata_i   request N (N=0,1), held until rN_ack_o
//   rN_ack_o/rdata_o/err_o  completion pulse, read data (held), timeout flag
//   qspi                   register bus to QSPI_master (master modport)
//   busy_o                 high whenever the sequencer is not idle
// Optional feature: define QSPI_ARB_TIMEOUT_EN to give up after TIMEOUT_CYCLES
// busy STA polls and complete with rN_err_o set.
module qspi_req_arbiter #(
    parameter int POLL_GAP       = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        r0_req_i,
    input  logic        r0_we_i,
    input  logic [31:0] r0_addr_i,
    input  logic [31:0] r0_ccr_i,
    input  logic [31:0] r0_wdata_i,
    output logic        r0_ack_o,
    output logic [31:0] r0_rdata_o,
    output logic        r0_err_o,
    input  logic        r1_req_i,
    input  logic        r1_we_i,
    input  logic [31:0] r1_addr_i,
    input  logic [31:0] r1_ccr_i,
    input  logic [31:0] r1_wdata_i,
    output logic        r1_ack_o,
    output logic [31:0] r1_rdata_o,
    output logic        r1_err_o,
    qspi_req_arbiter_if.master qspi,
    output logic        busy_o
);
    typedef enum logic [2:0] {IDLE, WR_DR, WR_ADR, WR_CCR, GAP, POLL, RD_DR, RESP} state_t;

    state_t      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] ccr_q, ccr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic [15:0] gap_q, gap_d;
    logic        pick1;
    logic        timeout;

    // r1 wins when it is alone, or when both ask and r0 was served last.
    assign pick1 = r1_req_i & (~r0_req_i | ~last_q);

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        ccr_d    = ccr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: if (r0_req_i | r1_req_i) begin
                gnt_d   = pick1;
                we_d    = pick1 ? r1_we_i    : r0_we_i;
                addr_d  = pick1 ? r1_addr_i  : r0_addr_i;
                ccr_d   = pick1 ? r1_ccr_i   : r0_ccr_i;
                wdata_d = pick1 ? r1_wdata_i : r0_wdata_i;
                state_d = we_d ? WR_DR : WR_ADR;
            end
            WR_DR:  state_d = WR_ADR;
            WR_ADR: state_d = WR_CCR;
            WR_CCR: begin
                gap_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                gap_d = gap_q + 16'd1;
                if (32'(gap_q) + 32'd1 >= POLL_GAP) state_d = POLL;
            end
            POLL: begin
                gap_d = '0;
                if (!qspi.rdata[0]) state_d = we_q ? RESP : RD_DR;
                else if (timeout) state_d = RESP;
                else state_d = GAP;
            end
            RD_DR: begin
                if (gnt_q) rdata1_d = qspi.rdata;
                else rdata0_d = qspi.rdata;
                state_d = RESP;
            end
            RESP: begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            ccr_q    <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            ccr_q    <= ccr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            gap_q    <= gap_d;
        end
    end

`ifdef QSPI_ARB_TIMEOUT_EN
    logic [15:0] poll_q, poll_d;
    logic        err_q, err_d;

    // Counts STA polls of the current operation; this poll is number poll_q+1.
    assign timeout = 32'(poll_q) + 32'd1 >= TIMEOUT_CYCLES;

    always_comb begin
        poll_d = poll_q;
        err_d  = err_q;
        if (state_q == IDLE) err_d = 1'b0;
        if (state_q == WR_CCR) poll_d = '0;
        if (state_q == POLL) begin
            poll_d = poll_q + 16'd1;
            err_d  = qspi.rdata[0] & timeout;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            poll_q <= '0;
            err_q  <= 1'b0;
        end else begin
            poll_q <= poll_d;
            err_q  <= err_d;
        end
    end

    assign r0_err_o = r0_ack_o & err_q;
    assign r1_err_o = r1_ack_o & err_q;
`else
    assign timeout  = 1'b0;
    assign r0_err_o = 1'b0;
    assign r1_err_o = 1'b0;
`endif

    assign busy_o     = state_q != IDLE;
    assign r0_ack_o   = (state_q == RESP) & ~gnt_q;
    assign r1_ack_o   = (state_q == RESP) & gnt_q;
    assign r0_rdata_o = rdata0_q;
    assign r1_rdata_o = rdata1_q;

    assign qspi.write = state_q inside {WR_DR, WR_ADR, WR_CCR};
    assign qspi.be    = (state_q inside {WR_DR, WR_ADR, WR_CCR, POLL, RD_DR}) ? 4'hF : 4'h0;
    assign qspi.addr  = (state_q == WR_ADR) ? 6'h04 :
                        (state_q == WR_DR || state_q == RD_DR) ? 6'h08 :
                        (state_q == POLL) ? 6'h28 : 6'h00;
    assign qspi.wdata = (state_q == WR_DR) ? wdata_q :
                        (state_q == WR_ADR) ? addr_q :
                        (state_q == WR_CCR) ? ccr_q : 32'h0;
endmodule
